// File: rtl/adbg_top_ctrl.sv
// adbg_top_ctrl: debug chain controller that owns the DEBUG data register, decodes module selects and routes TDO.
// Define ADBG_TOP_STATUS_EN to add the 24-bit status word and the sticky select/inhibit error flags.
module adbg_top_ctrl #(
    parameter int          NB_MODULES    = 4,
    parameter int          MODULE_ID_LEN = 2,
    parameter int          DATAREG_LEN   = 64,
    parameter logic [15:0] MODULE_MASK   = 16'h000F
) (
    input  logic                     tck_i,
    input  logic                     rst_i,
    input  logic                     tdi_i,
    output logic                     tdo_o,
    input  logic                     shift_dr_i,
    input  logic                     capture_dr_i,
    input  logic                     update_dr_i,
    input  logic                     debug_select_i,
    output logic [DATAREG_LEN-1:0]   data_register_o,
    output logic [NB_MODULES-1:0]    module_select_o,
    input  logic [NB_MODULES-1:0]    module_inhibit_i,
    input  logic [NB_MODULES-1:0]    module_tdo_i,
    output logic                     sel_valid_o,
    output logic [MODULE_ID_LEN-1:0] sel_id_o
);

    if (MODULE_ID_LEN < $clog2(NB_MODULES)) begin : g_bad_id_len
        $error("MODULE_ID_LEN too small for NB_MODULES");
    end
    if (DATAREG_LEN < 24 || DATAREG_LEN < MODULE_ID_LEN + 1) begin : g_bad_dr_len
        $error("DATAREG_LEN too small");
    end

    // Populated modules only; mask bits beyond NB_MODULES never count.
    localparam logic [15:0] MASK_EFF =
        MODULE_MASK & 16'((32'd1 << NB_MODULES) - 32'd1);

    logic [DATAREG_LEN-1:0]   sr_q, sr_d;
    logic                     sel_valid_q, sel_valid_d;
    logic [MODULE_ID_LEN-1:0] sel_id_q, sel_id_d;

    logic                     shift_en;
    logic                     cap_en;
    logic                     upd_en;
    logic [MODULE_ID_LEN-1:0] cmd_id;
    logic [31:0]              cmd_id_w;
    logic                     id_ok;
    logic                     set_sel_err;
    logic                     set_inh_err;
    logic                     tdo_sel;

    assign shift_en = debug_select_i && shift_dr_i;
    assign cap_en   = debug_select_i && capture_dr_i;
    assign upd_en   = debug_select_i && update_dr_i;
    assign cmd_id   = sr_q[DATAREG_LEN-2 -: MODULE_ID_LEN];
    assign cmd_id_w = 32'(cmd_id);
    assign id_ok    = (cmd_id_w < 32'(NB_MODULES)) && MASK_EFF[cmd_id_w[3:0]];

    always_comb begin
        sr_d        = sr_q;
        sel_valid_d = sel_valid_q;
        sel_id_d    = sel_id_q;
        set_sel_err = 1'b0;
        set_inh_err = 1'b0;
        if (shift_en) begin
            sr_d = {tdi_i, sr_q[DATAREG_LEN-1:1]};
        end
        // Updates with MSB clear belong to the selected module.
        if (upd_en && sr_q[DATAREG_LEN-1]) begin
            if (|module_inhibit_i) begin
                set_inh_err = 1'b1;
            end else if (id_ok) begin
                sel_valid_d = 1'b1;
                sel_id_d    = cmd_id;
            end else begin
                sel_valid_d = 1'b0;
                sel_id_d    = cmd_id;
                set_sel_err = 1'b1;
            end
        end
    end

    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            sr_q        <= '0;
            sel_valid_q <= 1'b0;
            sel_id_q    <= '0;
        end else begin
            sr_q        <= sr_d;
            sel_valid_q <= sel_valid_d;
            sel_id_q    <= sel_id_d;
        end
    end

    always_comb begin
        module_select_o = '0;
        tdo_sel         = 1'b0;
        for (int n = 0; n < NB_MODULES; n++) begin
            if (32'(sel_id_q) == 32'(n)) begin
                module_select_o[n] = sel_valid_q;
                tdo_sel            = module_tdo_i[n];
            end
        end
    end

`ifdef ADBG_TOP_STATUS_EN
    logic [23:0] status_q, status_d;
    logic        sel_err_q, sel_err_d;
    logic        inh_err_q, inh_err_d;
    logic [23:0] status_word;

    assign status_word = {MASK_EFF, 5'(NB_MODULES), inh_err_q, sel_err_q, sel_valid_q};

    always_comb begin
        status_d  = status_q;
        sel_err_d = sel_err_q;
        inh_err_d = inh_err_q;
        if (!sel_valid_q) begin
            if (cap_en) begin
                status_d  = status_word;
                sel_err_d = 1'b0;
                inh_err_d = 1'b0;
            end else if (shift_en) begin
                status_d = {1'b0, status_q[23:1]};
            end
        end
        // A set in the same cycle as a clear-on-read must not be lost.
        if (set_sel_err) begin
            sel_err_d = 1'b1;
        end
        if (set_inh_err) begin
            inh_err_d = 1'b1;
        end
    end

    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            status_q  <= '0;
            sel_err_q <= 1'b0;
            inh_err_q <= 1'b0;
        end else begin
            status_q  <= status_d;
            sel_err_q <= sel_err_d;
            inh_err_q <= inh_err_d;
        end
    end

    assign tdo_o = sel_valid_q ? tdo_sel : status_q[0];
`else
    logic unused_status;
    assign unused_status = ^{cap_en, set_sel_err, set_inh_err};
    assign tdo_o         = sel_valid_q ? tdo_sel : 1'b0;
`endif

    assign data_register_o = sr_q;
    assign sel_valid_o     = sel_valid_q;
    assign sel_id_o        = sel_id_q;

endmodule

// File: tb/tb_adbg_top_ctrl.sv
// tb_adbg_top_ctrl: random and directed stimulus against a queue-based reference of the chain controller.
// Checks every cycle; mask 0xFD with three modules makes ID 1 absent and ID 3 out of range.
module tb_adbg_top_ctrl;

    localparam int          NB   = 3;
    localparam int          IDW  = 2;
    localparam int          L    = 32;
    localparam logic [15:0] MASK = 16'h00FD;
`ifdef ADBG_TOP_STATUS_EN
    localparam bit STEN = 1'b1;
`else
    localparam bit STEN = 1'b0;
`endif

    logic          tck = 1'b0;
    logic          rst, tdi, sh, cap, upd, ds;
    logic          tdo, sv;
    logic [NB-1:0] inh, mtdo, msel;
    logic [L-1:0]  dr;
    logic [IDW-1:0] sid;

    always #5 tck = ~tck;

    adbg_top_ctrl #(
        .NB_MODULES   (NB),
        .MODULE_ID_LEN(IDW),
        .DATAREG_LEN  (L),
        .MODULE_MASK  (MASK)
    ) dut (
        .tck_i           (tck),
        .rst_i           (rst),
        .tdi_i           (tdi),
        .tdo_o           (tdo),
        .shift_dr_i      (sh),
        .capture_dr_i    (cap),
        .update_dr_i     (upd),
        .debug_select_i  (ds),
        .data_register_o (dr),
        .module_select_o (msel),
        .module_inhibit_i(inh),
        .module_tdo_i    (mtdo),
        .sel_valid_o     (sv),
        .sel_id_o        (sid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: shift register as a bit queue (index L-1 newest), status as a bit queue.
    bit m_sr[$];
    bit m_st[$];
    bit m_valid;
    int m_id;
    bit m_serr, m_ierr;

    function automatic void m_reset();
        m_sr.delete();
        for (int i = 0; i < L; i++) m_sr.push_back(1'b0);
        m_st.delete();
        m_valid = 0;
        m_id    = 0;
        m_serr  = 0;
        m_ierr  = 0;
    endfunction

    function automatic int m_cmd_id();
        int v = 0;
        for (int k = 0; k < IDW; k++) v += int'(m_sr[L-1-IDW+k]) << k;
        return v;
    endfunction

    function automatic void m_step();
        bit old_valid;
        bit s_set, i_set;
        int id, word;
        if (rst) begin
            m_reset();
            return;
        end
        if (!ds) return;
        old_valid = m_valid;
        s_set = 0;
        i_set = 0;
        if (upd && m_sr[L-1]) begin
            id = m_cmd_id();
            if (inh != 0) i_set = 1;
            else if (id < NB && MASK[id]) begin
                m_valid = 1;
                m_id    = id;
            end else begin
                m_valid = 0;
                m_id    = id;
                s_set   = 1;
            end
        end
        if (!old_valid && cap) begin
            word = (int'(m_serr) << 1) + (int'(m_ierr) << 2) + (NB << 3)
                 + ((int'(MASK) % (1 << NB)) << 8);
            m_st.delete();
            for (int i = 0; i < 24; i++) m_st.push_back(bit'((word >> i) & 1));
            m_serr = 0;
            m_ierr = 0;
        end
        if (!old_valid && sh && m_st.size() > 0) void'(m_st.pop_front());
        if (sh) begin
            void'(m_sr.pop_front());
            m_sr.push_back(tdi);
        end
        if (s_set) m_serr = 1;
        if (i_set) m_ierr = 1;
    endfunction

    // op: 0 idle, 1 shift, 2 capture, 3 update
    task automatic cyc(input bit r, input bit d, input int op, input bit t,
                       input logic [NB-1:0] ih);
        logic [L-1:0]  e_dr;
        logic [NB-1:0] e_sel;
        bit            e_tdo;
        rst  = r;
        ds   = d;
        sh   = (op == 1);
        cap  = (op == 2);
        upd  = (op == 3);
        tdi  = t;
        inh  = ih;
        mtdo = NB'($urandom);
        @(posedge tck);
        m_step();
        #1;
        for (int i = 0; i < L; i++) e_dr[i] = m_sr[i];
        e_sel = m_valid ? NB'(1 << m_id) : '0;
        if (m_valid) e_tdo = mtdo[m_id];
        else e_tdo = STEN && m_st.size() > 0 && m_st[0];
        chk("data_register", dr, e_dr);
        chk("module_select", msel, e_sel);
        chk("sel_valid", sv, m_valid);
        chk("sel_id", sid, m_id);
        chk("tdo", tdo, e_tdo);
    endtask

    task automatic sel(input int id, input logic [NB-1:0] ih);
        logic [L-1:0] w;
        w = L'($urandom);
        w[L-1] = 1'b1;
        w[L-2 -: IDW] = IDW'(id);
        for (int i = 0; i < L; i++) cyc(0, 1, 1, w[i], '0);
        cyc(0, 1, 3, 0, ih);
    endtask

    task automatic read_status(output logic [23:0] v);
        cyc(0, 1, 2, 0, '0);
        v[0] = tdo;
        for (int k = 1; k < 24; k++) begin
            cyc(0, 1, 1, 1'($urandom), '0);
            v[k] = tdo;
        end
    endtask

    logic [23:0] st;

    initial begin
        m_reset();
        cyc(1, 0, 0, 0, '0);
        cyc(1, 1, 1, 1, '1);
        chk("reset_msel", msel, 0);
        chk("reset_tdo", tdo, 0);
        chk("reset_dr", dr, 0);

        read_status(st);
        chk("status_after_reset", st, STEN ? 24'h000518 : 24'h0);

        sel(2, '0);
        chk("sel2_msel", msel, 3'b100);
        chk("sel2_valid", sv, 1);

        sel(1, '0);
        chk("absent_valid", sv, 0);
        chk("absent_msel", msel, 0);
        sel(0, '0);
        chk("sel0_msel", msel, 3'b001);

        sel(3, '0);
        chk("range_valid", sv, 0);
        read_status(st);
        chk("sel_err_set", st[1], STEN);
        read_status(st);
        chk("sel_err_cleared", st[1], 0);

        sel(0, '0);
        sel(2, 3'b010);
        chk("inhibit_keeps", msel, 3'b001);
        sel(1, '0);
        read_status(st);
        chk("inh_err_set", st[2], STEN);
        chk("sel_err_again", st[1], STEN);

        sel(2, '0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, 1, '0);
        cyc(1, 1, 1, 1, '0);
        chk("midshift_rst_msel", msel, 0);
        chk("midshift_rst_tdo", tdo, 0);
        chk("midshift_rst_dr", dr, 0);

        for (int c = 0; c < 3000; c++) begin
            int r;
            int op;
            logic [NB-1:0] ih;
            r  = $urandom_range(0, 9);
            op = (r < 2) ? 0 : (r < 7) ? 1 : (r == 7) ? 2 : 3;
            ih = ($urandom % 6 == 0) ? NB'($urandom) : '0;
            cyc(($urandom % 200) == 0, ($urandom % 8) != 0, op, 1'($urandom), ih);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adbg_top_ctrl.md
# adbg_top_ctrl

Parametrised top-level chain controller for the advanced debug interface. It owns the DEBUG-instruction data register. It decodes module-select commands for an arbitrary number of debug modules (bus, CPU, JSP, …) and routes TDO from the selected module. It rejects selects of absent modules and captures a top-level status word when no module is selected. It sits between the TAP controller and the per-module debug units, and every module takes its data register slice from `data_register_o`.

## Interface
Parameters:
- `NB_MODULES`, 4: number of module slots (1..16).
- `MODULE_ID_LEN`, 2: width of the module ID field. Must be ≥ $clog2(NB_MODULES); elaboration error otherwise.
- `DATAREG_LEN`, 64: length of the main shift register (≥ MODULE_ID_LEN+1 and ≥ 24).
- `MODULE_MASK`, 16'h000F: bit n=1 means module n is populated. Bits ≥ NB_MODULES are ignored.

Ports:
- `tck_i` in 1: JTAG TCK, the only clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `tdi_i` in 1: serial data in.
- `tdo_o` out 1: serial data out. Combinational from registers.
- `shift_dr_i`, `capture_dr_i`, `update_dr_i` in 1 each: TAP state decodes.
- `debug_select_i` in 1: DEBUG instruction active.
- `data_register_o` out DATAREG_LEN: main shift register contents.
- `module_select_o` out NB_MODULES: one-hot module select; all-zero when no module is selected.
- `module_inhibit_i` in NB_MODULES: module busy; blocks new selects.
- `module_tdo_i` in NB_MODULES: per-module TDO.
- `sel_valid_o` out 1: a module is selected.
- `sel_id_o` out MODULE_ID_LEN: current module ID.

## Operation
- Shift register `sr`:
  - When debug_select_i && shift_dr_i: `sr <= {tdi_i, sr[DATAREG_LEN-1:1]}` (LSB first; the newest bit enters at the MSB).
- Select command:
  - Recognised when sr[DATAREG_LEN-1]=1.
  - Module ID is `sr[DATAREG_LEN-2 -: MODULE_ID_LEN]`.
  - Evaluated on the cycle where debug_select_i && update_dr_i.
- Select evaluation, in priority order:
  - Any bit of module_inhibit_i set (including the inhibiting module's own bit): command ignored, `inh_err` set, ID and valid unchanged.
  - ID < NB_MODULES and MODULE_MASK[ID]=1: `sel_id <= ID`, `sel_valid <= 1`.
  - Otherwise: `sel_valid <= 0`, `sel_id <= ID`, `sel_err` set.
- Update with sr MSB=0: no effect on selection; belongs to the selected module.
- `module_select_o[n] = sel_valid && (sel_id == n)`.
- TDO mux:
  - `tdo_o = module_tdo_i[sel_id]` when sel_valid.
  - `tdo_o = status_sr[0]` when not sel_valid.
- Status path, active only while sel_valid=0:
  - On debug_select_i && capture_dr_i, load the 24-bit status word into `status_sr`:
    - [0] sel_valid (reads 0)
    - [1] sel_err
    - [2] inh_err
    - [7:3] NB_MODULES
    - [23:8] MODULE_MASK[15:0], with bits ≥ NB_MODULES forced to 0.
  - The same capture clears sel_err and inh_err (clear-on-read).
  - On shift, `status_sr <= {1'b0, status_sr[23:1]}`; zeros follow after bit 23.
- Simultaneous sticky set and clear is impossible (capture and update are exclusive TAP states). If both are asserted, set wins.

## Timing
- Reset values (rst_i high at a tck_i edge):
  - sr = 0, sel_valid = 0, sel_id = 0, sel_err = 0, inh_err = 0, status_sr = 0.
  - Resulting outputs: module_select_o = 0, tdo_o = 0, data_register_o = 0.
- Reset wins over every other input, including mid-shift and on an update cycle.
- Select latency:
  - module_select_o and sel_valid_o change one tck_i edge after the update_dr_i cycle.
  - The tdo_o source switches at that same edge.
- The shift register updates every shift cycle, regardless of selection.
- Status first bit:
  - The capture edge loads status_sr.
  - Status bit 0 is on tdo_o during the first shift cycle; bit k is on tdo_o after k shift edges.
- debug_select_i low: no shift, capture or update effect. Outputs still reflect the current registers.
- ID wrap: ID values ≥ NB_MODULES (up to 2^MODULE_ID_LEN−1) are invalid, not aliased.

## Configuration
- `ADBG_TOP_STATUS_EN` defined:
  - status_sr, sel_err and inh_err are implemented as described above.
- Not defined:
  - No status register and no sticky flags.
  - tdo_o = 0 whenever sel_valid=0.
  - Rejected and inhibited selects keep the same effect on sel_valid and sel_id.

## Test plan
- Reset, then capture and 24 shifts with `ADBG_TOP_STATUS_EN`, defaults → tdo_o sequence gives 24'h000F20: bit0=0, NB_MODULES=4 in [7:3], mask 0xF in [23:8].
- Shift 64 bits with MSB=1 and ID=2, then update → module_select_o=4'b0100 one edge later, sel_valid_o=1, tdo_o follows module_tdo_i[2].
- MODULE_MASK=16'h000B, select ID=2 → sel_valid_o=0, module_select_o=0. A following select of ID 0 succeeds and yields module_select_o=4'b0001.
- Select ID=2 after a rejected select (leaving sel_valid_o=0 and sel_err=1) → sel_valid_o=1. Select ID=3 after a rejected select, then deselect via a rejected select, then capture → status bit1=1. A second capture → bit1=0 (cleared).
- With module 1 selected and module_inhibit_i=4'b0010, select ID=3 → selection stays on 1. After deselecting via a rejected select, the status read shows inh_err=1.
- Assert rst_i mid-shift with module 2 selected → all registers 0 next edge, module_select_o=0, tdo_o=0.
